weight_tile_loader: RTL and testbench

Parametrised weight loader for the systolic CNN datapath. On a start pulse it streams one tile of convolution filters from an external single-port weight ROM, with configurable read latency, into a packed ROWS x COLS weight matrix. The matrix is ordered kernel-element by filter, ready for the PE array. Unlike the single-shot fill controller, it supports filter counts larger than the array by selecting a tile, pipelines ROM reads at one address per cycle, and reports a start/busy/done handshake with an error flag. It sits between the weight ROM and the array's weight registers, driven by the layer sequencer.

---
 rtl/weight_tile_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_weight_tile_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_loader.sv
// Streams one tile of convolution filters from a pipelined weight ROM into a
// packed rows x cols weight matrix (kernel element by filter) for the PE array.
module weight_tile_loader #(
  parameter int data_size     = 16,
  parameter int array_rows    = 9,
  parameter int array_cols    = 9,
  parameter int addr_size     = 15,
  parameter int dim_data_size = 16,
  parameter int read_latency  = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [addr_size-1:0]                        initial_address,
  input  logic [dim_data_size-1:0]                    weight_size,
  input  logic [dim_data_size-1:0]                    number_filters,
  input  logic [dim_data_size-1:0]                    tile_idx,
  output logic                                        rom_en,
  output logic [addr_size-1:0]                        rom_addr,
  input  logic [data_size-1:0]                        rom_data,
  output logic [data_size*array_rows*array_cols-1:0]  weight_out,
  output logic                                        weight_valid,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error
);

  localparam int EW    = $clog2(array_rows + 1);
  localparam int CW    = $clog2(array_cols + 1);
  localparam int LANES = array_rows * array_cols;
  localparam int LIW   = $clog2(LANES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [addr_size-1:0]     base_q, base_d;
  logic [dim_data_size-1:0] k_q, k_d, f_q, f_d, tile_q, tile_d;
  logic [EW-1:0]            e_tot_q, e_tot_d, e_q, e_d;
  logic [CW-1:0]            ft_q, ft_d, c_q, c_d;
  logic [31:0]              n_q, n_d, cap_q, cap_d;
  logic                     rom_en_q, rom_en_d;
  logic [addr_size-1:0]     rom_addr_q, rom_addr_d;
  logic [read_latency-1:0]  pv_q, pv_d;
  logic [EW-1:0]            tag_e_q [read_latency];
  logic [EW-1:0]            tag_e_d [read_latency];
  logic [CW-1:0]            tag_c_q [read_latency];
  logic [CW-1:0]            tag_c_d [read_latency];
  logic [data_size-1:0]     w_q [LANES];
  logic [data_size-1:0]     w_d [LANES];
  logic                     weight_valid_q, weight_valid_d;
  logic                     busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [31:0]    e32, lo32, rem32, ft32;
  logic           calc_err;
  logic [LIW-1:0] lane_idx;

  // Tile arithmetic from the registered request, all in 32 bits.
  always_comb begin
    e32      = 32'(k_q) * 32'(k_q);
    lo32     = 32'(tile_q) * 32'(array_cols);
    rem32    = 32'(f_q) - lo32;
    ft32     = (rem32 > 32'(array_cols)) ? 32'(array_cols) : rem32;
    calc_err = (k_q == '0) || (f_q == '0) || (e32 > 32'(array_rows)) ||
               (lo32 >= 32'(f_q));
    lane_idx = LIW'(tag_e_q[read_latency-1]) * LIW'(array_cols) +
               LIW'(tag_c_q[read_latency-1]);
  end

  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d        = state_q;
    base_d         = base_q;
    k_d            = k_q;
    f_d            = f_q;
    tile_d         = tile_q;
    e_tot_d        = e_tot_q;
    ft_d           = ft_q;
    n_d            = n_q;
    e_d            = e_q;
    c_d            = c_q;
    cap_d          = cap_q;
    rom_en_d       = rom_en_q;
    rom_addr_d     = rom_addr_q;
    w_d            = w_q;
    weight_valid_d = weight_valid_q;
    done_d         = 1'b0;
    error_d        = 1'b0;

    // Each issued read carries its (element, filter) tag down the pipe.
    pv_d[0]    = rom_en_q;
    tag_e_d[0] = e_q;
    tag_c_d[0] = c_q;
    for (int i = 1; i < read_latency; i++) begin
      pv_d[i]    = pv_q[i-1];
      tag_e_d[i] = tag_e_q[i-1];
      tag_c_d[i] = tag_c_q[i-1];
    end

    if (pv_q[read_latency-1]) begin
      w_d[lane_idx] = rom_data;
      cap_d         = cap_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = initial_address;
          k_d     = weight_size;
          f_d     = number_filters;
          tile_d  = tile_idx;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        w_d            = '{default: '0};
        weight_valid_d = 1'b0;
        if (calc_err) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d    = S_ISSUE;
          rom_en_d   = 1'b1;
          rom_addr_d = base_q + addr_size'(lo32 * e32);
          e_tot_d    = EW'(e32);
          ft_d       = CW'(ft32);
          n_d        = e32 * ft32;
          e_d        = '0;
          c_d        = '0;
          cap_d      = '0;
        end
      end
      S_ISSUE: begin
        // Filter-major order makes the addresses of a tile contiguous.
        if (e_q == e_tot_q - EW'(1) && c_q == ft_q - CW'(1)) begin
          rom_en_d = 1'b0;
          state_d  = S_DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + addr_size'(1);
          if (e_q == e_tot_q - EW'(1)) begin
            e_d = '0;
            c_d = c_q + CW'(1);
          end else begin
            e_d = e_q + EW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pv_q[read_latency-1] && (cap_q + 32'd1 == n_q)) begin
          state_d        = S_DONE;
          done_d         = 1'b1;
          weight_valid_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      k_q            <= '0;
      f_q            <= '0;
      tile_q         <= '0;
      e_tot_q        <= '0;
      ft_q           <= '0;
      n_q            <= '0;
      e_q            <= '0;
      c_q            <= '0;
      cap_q          <= '0;
      rom_en_q       <= 1'b0;
      rom_addr_q     <= '0;
      pv_q           <= '0;
      tag_e_q        <= '{default: '0};
      tag_c_q        <= '{default: '0};
      // NOTE: the weight storage is reset too, because weight_out is a
      // visible output that must read zero out of reset.
      w_q            <= '{default: '0};
      weight_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      k_q            <= k_d;
      f_q            <= f_d;
      tile_q         <= tile_d;
      e_tot_q        <= e_tot_d;
      ft_q           <= ft_d;
      n_q            <= n_d;
      e_q            <= e_d;
      c_q            <= c_d;
      cap_q          <= cap_d;
      rom_en_q       <= rom_en_d;
      rom_addr_q     <= rom_addr_d;
      pv_q           <= pv_d;
      tag_e_q        <= tag_e_d;
      tag_c_q        <= tag_c_d;
      w_q            <= w_d;
      weight_valid_q <= weight_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) weight_out[i*data_size +: data_size] = w_q[i];
  end

  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;
  assign weight_valid = weight_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed and randomized bench for weight_tile_loader: three instances with ROM
// latencies 1, 2 and 4, checked against a tile model computed from plain arithmetic.
module tb_weight_tile_loader;

  localparam int W  = 16 * 9 * 9;
  localparam int L2 = 2;

  logic clk, rst_n, start;
  logic [14:0] initial_address;
  logic [15:0] weight_size, number_filters, tile_idx;

  logic          rom_en1, rom_en2, rom_en4;
  logic [14:0]   rom_addr1, rom_addr2, rom_addr4;
  logic [15:0]   rom_data1, rom_data2, rom_data4;
  logic [W-1:0]  weight_out1, weight_out2, weight_out4;
  logic          wv1, wv2, wv4, busy1, busy2, busy4;
  logic          done1, done2, done4, err1, err2, err4;

  weight_tile_loader #(.read_latency(1)) dut1 (
    .clk(clk), .reset(rst_n), .start(start), .initial_address(initial_address),
    .weight_size(weight_size), .number_filters(number_filters), .tile_idx(tile_idx),
    .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .weight_out(weight_out1), .weight_valid(wv1), .busy(busy1), .done(done1), .error(err1));

  weight_tile_loader #(.read_latency(L2)) dut (
    .clk(clk), .reset(rst_n), .start(start), .initial_address(initial_address),
    .weight_size(weight_size), .number_filters(number_filters), .tile_idx(tile_idx),
    .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .weight_out(weight_out2), .weight_valid(wv2), .busy(busy2), .done(done2), .error(err2));

  weight_tile_loader #(.read_latency(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(start), .initial_address(initial_address),
    .weight_size(weight_size), .number_filters(number_filters), .tile_idx(tile_idx),
    .rom_en(rom_en4), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .weight_out(weight_out4), .weight_valid(wv4), .busy(busy4), .done(done4), .error(err4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: not reset, so data already in flight keeps arriving after a DUT reset.
  logic [15:0] rom_mem [32768];
  logic [15:0] p1;
  logic [15:0] p2 [2];
  logic [15:0] p4 [4];
  initial begin
    p1 = '0;
    p2 = '{default: '0};
    p4 = '{default: '0};
  end
  always @(posedge clk) begin
    p1    <= rom_en1 ? rom_mem[rom_addr1] : 16'hDEAD;
    p2[0] <= rom_en2 ? rom_mem[rom_addr2] : 16'hDEAD;
    p2[1] <= p2[0];
    p4[0] <= rom_en4 ? rom_mem[rom_addr4] : 16'hDEAD;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign rom_data1 = p1;
  assign rom_data2 = p2[1];
  assign rom_data4 = p4[3];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one tile request.
  logic [15:0] exp_w [81];
  int          exp_addr [$];
  int          exp_n;
  bit          exp_err;

  task automatic clear_exp();
    for (int i = 0; i < 81; i++) exp_w[i] = '0;
    exp_addr.delete();
    exp_n = 0;
  endtask

  task automatic model(input int base, input int k, input int f, input int tile);
    int e, lo, ft, a;
    clear_exp();
    e  = k * k;
    lo = tile * 9;
    exp_err = (k == 0) || (f == 0) || (e > 9) || (lo >= f);
    if (!exp_err) begin
      ft = (f - lo < 9) ? f - lo : 9;
      for (int c = 0; c < ft; c++)
        for (int ee = 0; ee < e; ee++) begin
          a = (base + (lo + c) * e + ee) % 32768;
          exp_addr.push_back(a);
          exp_w[ee*9 + c] = rom_mem[a];
          exp_n++;
        end
    end
  endtask

  task automatic check_tile(input string tag, input logic [W-1:0] w);
    for (int r = 0; r < 9; r++) begin
      logic [143:0] e_row;
      for (int c = 0; c < 9; c++) e_row[c*16 +: 16] = exp_w[r*9 + c];
      check($sformatf("%s_row%0d", tag, r), w[r*144 +: 144], e_row);
    end
  endtask

  task automatic start_pulse(input int base, input int k, input int f, input int tile);
    initial_address = 15'(base);
    weight_size     = 16'(k);
    number_filters  = 16'(f);
    tile_idx        = 16'(tile);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int cyc_done, en_cnt, addr_bad, busy_bad;
  bit wv_at2;

  // Follows the latency-2 instance from the CALC cycle up to its done pulse.
  task automatic watch(input int extra_start_cyc);
    int cyc;
    cyc = 1; cyc_done = -1; en_cnt = 0; addr_bad = 0; busy_bad = 0; wv_at2 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      start = (cyc == extra_start_cyc);
      if (!busy2) busy_bad++;
      if (cyc == 2) wv_at2 = wv2;
      if (rom_en2) begin
        if (en_cnt >= exp_addr.size() || int'(rom_addr2) != exp_addr[en_cnt]) addr_bad++;
        en_cnt++;
      end
      if (done2) begin
        cyc_done = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    check({tag, "_latency"}, cyc_done, exp_err ? 2 : exp_n + L2 + 2);
    check({tag, "_rom_en_cycles"}, en_cnt, exp_n);
    check({tag, "_bad_addresses"}, addr_bad, 0);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_valid_cleared"}, wv_at2, 0);
    check({tag, "_error"}, err2, exp_err);
    check({tag, "_weight_valid"}, wv2, !exp_err);
    check_tile(tag, weight_out2);
    @(posedge clk); #1;
    check({tag, "_after_done"}, {done2, err2, busy2, wv2}, {3'b000, !exp_err});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int d1, d2, d4, stale_bad, base, k, f, tile;
    for (int i = 0; i < 32768; i++) rom_mem[i] = 16'(i);
    rst_n = 1'b0; start = 1'b0;
    initial_address = '0; weight_size = '0; number_filters = '0; tile_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    clear_exp();
    check("reset_ctrl", {rom_en2, rom_addr2, wv2, busy2, done2, err2}, 0);
    check_tile("reset", weight_out2);
    rst_n = 1'b1;
    idle(2);

    // Basic load.
    model(100, 3, 4, 0);
    start_pulse(100, 3, 4, 0);
    watch(0);
    finish_load("basic");
    idle(5);

    // Tile 1 of a 12-filter layer.
    model(0, 2, 12, 1);
    start_pulse(0, 2, 12, 1);
    watch(0);
    finish_load("tile1");
    idle(5);

    // Invalid requests.
    model(0, 4, 4, 0);
    start_pulse(0, 4, 4, 0);
    watch(0);
    finish_load("err_k4");
    idle(5);
    model(0, 3, 9, 1);
    start_pulse(0, 3, 9, 1);
    watch(0);
    finish_load("err_tile");
    idle(5);

    // Address wrap.
    model(32766, 1, 4, 0);
    start_pulse(32766, 1, 4, 0);
    watch(0);
    finish_load("wrap");
    idle(5);

    // Inputs changed and start re-pulsed during the load are both ignored.
    model(100, 3, 4, 0);
    start_pulse(100, 3, 4, 0);
    initial_address = '0; weight_size = 16'd1; number_filters = 16'd1; tile_idx = '0;
    watch(5);
    finish_load("busy_start");
    // Back-to-back start in the first cycle after DONE.
    model(500, 2, 5, 0);
    start_pulse(500, 2, 5, 0);
    watch(0);
    finish_load("back_to_back");
    idle(8);

    // Reset in the middle of DRAIN; stale ROM data must not be captured.
    model(100, 3, 4, 0);
    start_pulse(100, 3, 4, 0);
    idle(37);
    check("pre_reset_drain", {rom_en2, busy2}, 2'b01);
    rst_n = 1'b0;
    #1;
    clear_exp();
    check("mid_reset_ctrl", {rom_en2, rom_addr2, wv2, busy2, done2, err2}, 0);
    check_tile("mid_reset", weight_out2);
    #1;
    rst_n = 1'b1;
    stale_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (weight_out2 !== '0 || busy2 || wv2) stale_bad++;
    end
    check("stale_capture", stale_bad, 0);
    model(200, 3, 7, 0);
    start_pulse(200, 3, 7, 0);
    watch(0);
    finish_load("after_reset");
    idle(8);

    // Latency sweep on all three instances at once.
    model(100, 3, 4, 0);
    start_pulse(100, 3, 4, 0);
    d1 = -1; d2 = -1; d4 = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (done1 && d1 < 0) begin d1 = cyc; check_tile("lat1", weight_out1); end
      if (done2 && d2 < 0) begin d2 = cyc; check_tile("lat2", weight_out2); end
      if (done4 && d4 < 0) begin d4 = cyc; check_tile("lat4", weight_out4); end
      if (d1 >= 0 && d2 >= 0 && d4 >= 0) break;
      @(posedge clk); #1;
    end
    check("sweep_done_lat1", d1, exp_n + 1 + 2);
    check("sweep_done_lat2", d2, exp_n + 2 + 2);
    check("sweep_done_lat4", d4, exp_n + 4 + 2);
    idle(8);

    // Randomized requests over random ROM contents.
    for (int i = 0; i < 32768; i++) rom_mem[i] = 16'($urandom);
    for (int t = 0; t < 10; t++) begin
      base = int'($urandom_range(0, 32767));
      k    = int'($urandom_range(0, 4));
      f    = int'($urandom_range(0, 30));
      tile = int'($urandom_range(0, 3));
      model(base, k, f, tile);
      start_pulse(base, k, f, tile);
      watch(0);
      finish_load($sformatf("rand%0d", t));
      idle(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
